bcd_digit_formatter: RTL and testbench
======================================

Name: bcd_digit_formatter

Overview:
- Downstream stage of the sequential binary-to-BCD converter.
- Accepts one packed 4-digit BCD word through a valid/ready handshake.
- Runs a 4-cycle MSD-to-LSD scan that applies leading-zero blanking and flags illegal digits.
- Commits all four active-low 7-segment codes (DE2 HEX format, bit0 = segment a) together, so the displays never show a partly updated value.

Parameters:
- BLANK_LEADING, 1: 1 = suppress leading zeros; 0 = show every digit.
- FLASH_CYCLES, 3375000: blank-flash length in clk cycles (125 ms at 27 MHz). Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_27 domain)
- rst_n  in  1  asynchronous active-low reset
- bcd_in  in  16  {d3,d2,d1,d0}, 4 bits per digit, d3 = thousands
- bcd_valid  in  1  bcd_in is valid this cycle
- ready  out  1  block can accept a word
- hex0  out  7  units segments, active-low
- hex1  out  7  tens segments
- hex2  out  7  hundreds segments
- hex3  out  7  thousands segments
- update  out  1  one-cycle pulse when new segment codes are committed

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; ready=1; update=0.
  - hex0..hex3 = 7'h7F (all blank); shadow registers and the leading flag are cleared.
- Reset asserted mid-scan aborts the scan. No partial commit occurs.
- States:
  - IDLE: ready=1. When bcd_valid=1 at a rising edge, capture bcd_in, set leading=BLANK_LEADING, set idx=3, go to SCAN.
  - SCAN: ready=0. Each cycle processes digit idx into shadow[idx]. idx decrements each cycle; after idx=0, go to COMMIT.
  - COMMIT: ready=0. Copy shadow[3:0] to hex3..hex0, pulse update=1, go to IDLE.
- Latency, with the accept edge as edge 0:
  - Digits 3, 2, 1, 0 are processed on edges 1–4.
  - hex outputs and update are registered on edge 5.
  - ready is 0 after edge 0 and returns to 1 after edge 5.
  - Throughput is one word per 6 cycles.
- Digit rules, applied in order:
  - Digit > 9: encode 'E' (7'h06) and clear leading.
  - Digit == 0, leading=1 and idx != 0: encode blank (7'h7F); leading stays 1.
  - Otherwise: normal encode and clear leading.
- Digit 0 is never blanked, so a value of zero displays "0".
- Segment codes 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- bcd_valid while ready=0 is ignored and the word is dropped. The upstream block must hold bcd_valid until ready=1.
- bcd_in is sampled only on the accept edge; later changes do not affect the scan in progress.
- hex outputs hold their value between commits.

Optional Feature:
- Macro: BCD_FMT_FLASH_EN.
- Defined:
  - When a commit produces segment codes that differ from the currently displayed codes, a counter loads FLASH_CYCLES-1.
  - hex0..hex3 read 7'h7F until the counter reaches 0, then show the committed codes.
  - update still pulses on edge 5.
  - ready is unaffected during the flash.
  - A new differing commit during a flash reloads the counter.
  - An identical commit does not start a flash.
  - Reset clears the counter.
- Undefined: no counter is instantiated, and outputs follow commits directly.

Decomposition:
- Package bcd_fmt_pkg:
  - typedef bcd_digit_t (logic [3:0]) and seg7_t (logic [6:0]).
  - enum fmt_state_t {IDLE, SCAN, COMMIT}.
  - Constants SEG_BLANK = 7'h7F and SEG_E = 7'h06.
  - Constant array SEG_DIGIT[0:9].
- Sub-module bcd_to_seg7: combinational, maps bcd_digit_t to seg7_t, with 'E' for inputs > 9. Instantiated once and driven by the digit selected by idx.

Test Plan:
1. Reset, then bcd_in=16'h0123 with valid for 1 cycle -> ready low for 5 cycles; on edge 5 hex3=7F, hex2=79, hex1=24, hex0=30, update=1 for exactly one cycle.
2. bcd_in=16'h0000 -> hex3=7F, hex2=7F, hex1=7F, hex0=40. With BLANK_LEADING=0 -> all four = 40.
3. bcd_in=16'h4095 -> hex3=19, hex2=40, hex1=10, hex0=12 (inner zero shown).
4. bcd_in=16'h0A05 -> hex3=7F, hex2=06, hex1=40, hex0=12. After that word, pulse valid with 16'h1111 on edge 2 while ready=0 -> word ignored, outputs unchanged, no second update pulse.
5. Accept 16'h9999, assert rst_n=0 after edge 2 -> all hex=7F, ready=1, update=0 immediately. After release, accept 16'h0007 -> hex0=78 and the others 7F, 6 edges later.
6. With BCD_FMT_FLASH_EN defined and FLASH_CYCLES=4:
   - Commit 16'h0012 over a display of 0007 -> hex all 7F for 4 cycles, then 7F, 7F, 79, 24.
   - Re-commit 16'h0012 -> no blanking.

Source files
------------

// File: rtl/bcd_digit_formatter_pkg.sv
// Shared types and segment constants for the BCD digit formatter.
// Segment codes are active-low DE2 HEX format, bit0 = segment a.
package bcd_fmt_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg7_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } fmt_state_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_E     = 7'h06;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_digit_formatter_if.sv
// Valid/ready word stream from the binary-to-BCD converter into the formatter.
interface bcd_digit_formatter_if;

  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        ready;

  modport master (output bcd_in, output bcd_valid, input ready);
  modport slave  (input bcd_in, input bcd_valid, output ready);

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment encoder; non-decimal digits show 'E'.
module bcd_to_seg7
  import bcd_fmt_pkg::*;
(
  input  bcd_digit_t digit,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_E;
    if (digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/bcd_digit_formatter.sv
// Four-digit BCD to 7-segment formatter with leading-zero blanking and atomic commit.
// Optional blank-flash on changed values is enabled with `define BCD_FMT_FLASH_EN.
//
// state  | meaning
// IDLE   | ready=1, waiting for a word
// SCAN   | one digit per cycle, idx 3 down to 0, into shadow
// COMMIT | shadow copied to the displays, update pulsed
module bcd_digit_formatter
  import bcd_fmt_pkg::*;
#(
  parameter int BLANK_LEADING = 1,
  parameter int FLASH_CYCLES  = 3375000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bcd_digit_formatter_if.slave        bus,
  output seg7_t                       hex0,
  output seg7_t                       hex1,
  output seg7_t                       hex2,
  output seg7_t                       hex3,
  output logic                        update
);

  if (FLASH_CYCLES < 1 || BLANK_LEADING < 0 || BLANK_LEADING > 1) begin : g_param_check
    $error("bcd_digit_formatter: FLASH_CYCLES must be >= 1 and BLANK_LEADING 0 or 1");
  end

  fmt_state_t state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       leading, leading_nxt;
  logic       shadow_we;
  seg7_t      shadow_val;

  logic [15:0] bcd_q;
  seg7_t       shadow [4];
  seg7_t       disp_q [4];
  logic        update_q;

  bcd_digit_t cur_digit;
  seg7_t      cur_seg;
  logic       accept;
  logic       commit;

  assign cur_digit = bcd_q[{idx, 2'b00} +: 4];
  assign accept    = (state == IDLE) && bus.bcd_valid;
  assign commit    = (state == COMMIT);
  assign bus.ready = (state == IDLE);
  assign update    = update_q;

  bcd_to_seg7 u_enc (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      leading <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      leading <= leading_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    leading_nxt = leading;
    shadow_we   = 1'b0;
    shadow_val  = cur_seg;
    case (state)
      IDLE: begin
        if (bus.bcd_valid) begin
          state_nxt   = SCAN;
          idx_nxt     = 2'd3;
          leading_nxt = (BLANK_LEADING != 0);
        end
      end
      SCAN: begin
        shadow_we = 1'b1;
        // Units digit is never blanked so a zero value still shows "0".
        if (cur_digit > 4'd9) begin
          shadow_val  = SEG_E;
          leading_nxt = 1'b0;
        end else if (cur_digit == 4'd0 && leading && idx != 2'd0) begin
          shadow_val  = SEG_BLANK;
        end else begin
          leading_nxt = 1'b0;
        end
        idx_nxt = idx - 2'd1;
        if (idx == 2'd0) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= 16'h0000;
      update_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= SEG_BLANK;
        disp_q[i] <= SEG_BLANK;
      end
    end else begin
      update_q <= commit;
      if (accept) begin
        bcd_q <= bus.bcd_in;
      end
      if (shadow_we) begin
        shadow[idx] <= shadow_val;
      end
      if (commit) begin
        for (int i = 0; i < 4; i++) begin
          disp_q[i] <= shadow[i];
        end
      end
    end
  end

`ifdef BCD_FMT_FLASH_EN
  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  logic [CW-1:0] flash_cnt;
  logic          flash_on;
  logic          commit_differs;

  assign commit_differs = commit &&
    ({shadow[3], shadow[2], shadow[1], shadow[0]} != {disp_q[3], disp_q[2], disp_q[1], disp_q[0]});

  // Displays stay blank from the load until the cycle after terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
      flash_on  <= 1'b0;
    end else if (commit_differs) begin
      flash_cnt <= CW'(FLASH_CYCLES - 1);
      flash_on  <= 1'b1;
    end else if (flash_on) begin
      if (flash_cnt == '0) begin
        flash_on <= 1'b0;
      end else begin
        flash_cnt <= flash_cnt - 1'b1;
      end
    end
  end

  assign hex0 = flash_on ? SEG_BLANK : disp_q[0];
  assign hex1 = flash_on ? SEG_BLANK : disp_q[1];
  assign hex2 = flash_on ? SEG_BLANK : disp_q[2];
  assign hex3 = flash_on ? SEG_BLANK : disp_q[3];
`else
  assign hex0 = disp_q[0];
  assign hex1 = disp_q[1];
  assign hex2 = disp_q[2];
  assign hex3 = disp_q[3];
`endif

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Directed bench for bcd_digit_formatter: latency, blanking, illegal digits, drop and reset abort.
`timescale 1ns/1ps
module tb_bcd_digit_formatter;
  import bcd_fmt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_formatter_if ifc ();
  bcd_digit_formatter_if ifc_nb ();

  seg7_t h0, h1, h2, h3;
  seg7_t nb0, nb1, nb2, nb3;
  logic  upd, nb_upd;

  bcd_digit_formatter #(.BLANK_LEADING(1), .FLASH_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .update(upd)
  );

  bcd_digit_formatter #(.BLANK_LEADING(0), .FLASH_CYCLES(4)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(ifc_nb.slave),
    .hex0(nb0), .hex1(nb1), .hex2(nb2), .hex3(nb3), .update(nb_upd)
  );

`ifdef BCD_FMT_FLASH_EN
  bcd_digit_formatter_if ifc_fl ();
  seg7_t fl0, fl1, fl2, fl3;
  logic  fl_upd;

  bcd_digit_formatter #(.BLANK_LEADING(1), .FLASH_CYCLES(4)) dut_fl (
    .clk(clk), .rst_n(rst_n), .bus(ifc_fl.slave),
    .hex0(fl0), .hex1(fl1), .hex2(fl2), .hex3(fl3), .update(fl_upd)
  );
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w);
    ifc.bcd_valid    = v;
    ifc.bcd_in       = w;
    ifc_nb.bcd_valid = v;
    ifc_nb.bcd_in    = w;
`ifdef BCD_FMT_FLASH_EN
    ifc_fl.bcd_valid = v;
    ifc_fl.bcd_in    = w;
`endif
  endtask

  // Returns one step after the accept edge; bcd_in is then scrambled.
  task automatic send_word(input logic [15:0] w);
    int waited = 0;
    while (!ifc.ready && waited < 20) begin
      tick(1);
      waited++;
    end
    chk("ready_wait", {31'd0, ifc.ready}, 32'd1);
    drive(1'b1, w);
    tick(1);
    drive(1'b0, 16'hBEEF);
  endtask

  task automatic chk_hex(input string tag, input seg7_t e3, input seg7_t e2,
                         input seg7_t e1, input seg7_t e0);
    chk({tag, "_hex3"}, {25'd0, h3}, {25'd0, e3});
    chk({tag, "_hex2"}, {25'd0, h2}, {25'd0, e2});
    chk({tag, "_hex1"}, {25'd0, h1}, {25'd0, e1});
    chk({tag, "_hex0"}, {25'd0, h0}, {25'd0, e0});
  endtask

  task automatic run_word(input string tag, input logic [15:0] w, input seg7_t e3,
                          input seg7_t e2, input seg7_t e1, input seg7_t e0);
    send_word(w);
    chk({tag, "_ready_e0"}, {31'd0, ifc.ready}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk({tag, "_ready_scan"}, {31'd0, ifc.ready}, 32'd0);
      chk({tag, "_upd_scan"}, {31'd0, upd}, 32'd0);
    end
    tick(1);
    chk_hex(tag, e3, e2, e1, e0);
    chk({tag, "_upd_e5"}, {31'd0, upd}, 32'd1);
    chk({tag, "_ready_e5"}, {31'd0, ifc.ready}, 32'd1);
    tick(1);
    chk({tag, "_upd_e6"}, {31'd0, upd}, 32'd0);
    chk_hex({tag, "_hold"}, e3, e2, e1, e0);
  endtask

  initial begin
    drive(1'b0, 16'h0000);
    rst_n = 1'b0;
    tick(2);
    chk_hex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("reset_ready", {31'd0, ifc.ready}, 32'd1);
    chk("reset_upd", {31'd0, upd}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    run_word("w0123", 16'h0123, 7'h7F, 7'h79, 7'h24, 7'h30);

    run_word("w0000", 16'h0000, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    chk("nb0000_hex3", {25'd0, nb3}, 32'h40);
    chk("nb0000_hex2", {25'd0, nb2}, 32'h40);
    chk("nb0000_hex1", {25'd0, nb1}, 32'h40);
    chk("nb0000_hex0", {25'd0, nb0}, 32'h40);

    run_word("w4095", 16'h4095, 7'h19, 7'h40, 7'h10, 7'h12);
    chk("nb4095_hex2", {25'd0, nb2}, 32'h40);

    // Word offered on edge 2 during a scan must be dropped.
    send_word(16'h0A05);
    tick(1);
    drive(1'b1, 16'h1111);
    tick(1);
    drive(1'b0, 16'h0000);
    tick(3);
    chk_hex("w0A05", 7'h7F, 7'h06, 7'h40, 7'h12);
    chk("w0A05_upd_e5", {31'd0, upd}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("drop_upd", {31'd0, upd}, 32'd0);
      chk("drop_ready", {31'd0, ifc.ready}, 32'd1);
    end
    chk_hex("drop_hold", 7'h7F, 7'h06, 7'h40, 7'h12);

    // Reset in the middle of a scan aborts it with no commit.
    send_word(16'h9999);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_hex("rst_mid", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("rst_mid_ready", {31'd0, ifc.ready}, 32'd1);
    chk("rst_mid_upd", {31'd0, upd}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk_hex("rst_hold", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("rst_hold_upd", {31'd0, upd}, 32'd0);
    run_word("w0007", 16'h0007, 7'h7F, 7'h7F, 7'h7F, 7'h78);

`ifdef BCD_FMT_FLASH_EN
    tick(6);
    chk("fl_pre_hex0", {25'd0, fl0}, 32'h78);
    send_word(16'h0012);
    tick(5);
    chk("fl_upd_e5", {31'd0, fl_upd}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("fl_blank_hex0", {25'd0, fl0}, 32'h7F);
      chk("fl_blank_hex1", {25'd0, fl1}, 32'h7F);
      if (i < 3) tick(1);
    end
    tick(1);
    chk("fl_show_hex3", {25'd0, fl3}, 32'h7F);
    chk("fl_show_hex2", {25'd0, fl2}, 32'h7F);
    chk("fl_show_hex1", {25'd0, fl1}, 32'h79);
    chk("fl_show_hex0", {25'd0, fl0}, 32'h24);
    send_word(16'h0012);
    tick(5);
    chk("fl_same_upd", {31'd0, fl_upd}, 32'd1);
    chk("fl_same_hex1", {25'd0, fl1}, 32'h79);
    chk("fl_same_hex0", {25'd0, fl0}, 32'h24);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
